hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core. It keeps a registered shadow of the destination/source register tags for the E, M and W stages and drives the execute stage's forwarding mux selects. It also produces the fetch/decode stall and decode/execute flush strobes for load-use hazards and taken branches/jumps. It sits beside the pipeline registers and is the only source of their stall/flush controls.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_fwd_sel.sv | 21 ++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller: result-source and
// forward-select encodings plus the per-stage register tag.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic [1:0]       res_src;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One execute-stage forward select from the M and W shadow tags.
// M has priority over W, and x0 never forwards.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_e_i,
    input  stage_tag_t       m_tag_i,
    input  stage_tag_t       w_tag_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (m_tag_i.reg_write && (m_tag_i.rd != '0) && (m_tag_i.rd == rs_e_i)) begin
            sel_o = FWD_M;
        end else if (w_tag_i.reg_write && (w_tag_i.rd != '0) && (w_tag_i.rd == rs_e_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 core: E/M/W tag shadow, forwarding,
// load-use stall and branch flush. Define HAZARD_MULDIV_EN for multi-cycle mul/div stalls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int         REG_ADDR_WIDTH = REG_W,
    parameter logic [1:0] LOAD_RES_SRC   = RES_LOAD,
    parameter int         MULDIV_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      reg_write_d,
    input  logic [1:0]                res_src_d,
    input  logic                      pc_src_e,
    input  logic                      muldiv_d,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      stall_e
);

    stage_tag_t e_tag_q, m_tag_q, w_tag_q;
    stage_tag_t e_tag_d, m_tag_d, w_tag_d;
    stage_tag_t dec_tag;
    logic       load_use;
    logic       md_busy;

    always_comb begin
        dec_tag           = BUBBLE;
        dec_tag.rs1       = rs1_d;
        dec_tag.rs2       = rs2_d;
        dec_tag.rd        = rd_d;
        dec_tag.reg_write = reg_write_d;
        dec_tag.res_src   = res_src_d;
    end

    assign load_use = (e_tag_q.res_src == LOAD_RES_SRC) && (e_tag_q.rd != '0) &&
                      ((e_tag_q.rd == rs1_d) || (e_tag_q.rd == rs2_d));

`ifdef HAZARD_MULDIV_EN
    localparam int CNT_W = $clog2(MULDIV_LATENCY) + 1;

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    assign md_busy = (md_cnt_q != '0);

    // The counter is armed on the edge the mul/div is accepted into E.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else if (muldiv_d && !flush_e) begin
            md_cnt_d = CNT_W'(MULDIV_LATENCY - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end
`else
    logic unused_muldiv;

    assign md_busy       = 1'b0;
    assign unused_muldiv = muldiv_d & (MULDIV_LATENCY > 0);
`endif

    // A taken branch overrides every stall; a busy mul/div holds E so it cannot also flush.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (md_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        w_tag_d = m_tag_q;
        if (md_busy) begin
            e_tag_d = e_tag_q;
            m_tag_d = BUBBLE;
        end else begin
            e_tag_d = flush_e ? BUBBLE : dec_tag;
            m_tag_d = e_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_tag_q <= BUBBLE;
            m_tag_q <= BUBBLE;
            w_tag_q <= BUBBLE;
        end else begin
            e_tag_q <= e_tag_d;
            m_tag_q <= m_tag_d;
            w_tag_q <= w_tag_d;
        end
    end

    hazard_ctrl_fwd_sel u_fwd_sel_a (
        .rs_e_i  (e_tag_q.rs1),
        .m_tag_i (m_tag_q),
        .w_tag_i (w_tag_q),
        .sel_o   (forward_a_e)
    );

    hazard_ctrl_fwd_sel u_fwd_sel_b (
        .rs_e_i  (e_tag_q.rs2),
        .m_tag_i (m_tag_q),
        .w_tag_i (w_tag_q),
        .sel_o   (forward_b_e)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction-sequence table, mul/div sequence
// (when HAZARD_MULDIV_EN is defined) and random traffic against an in-flight instruction model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       reg_write_d;
    logic [1:0] res_src_d;
    logic       pc_src_e, muldiv_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e, stall_e;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_d        (rd_d),
        .reg_write_d (reg_write_d),
        .res_src_d   (res_src_d),
        .pc_src_e    (pc_src_e),
        .muldiv_d    (muldiv_d),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .stall_e     (stall_e)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       we;
        logic [1:0] res;
        logic       pc, md;
        logic [1:0] fa, fb;
        logic [4:0] ctl;   // {stall_f, stall_d, stall_e, flush_d, flush_e}
    } vec_t;

    // In-flight instruction record; index 0 = execute, 1 = memory, 2 = writeback.
    typedef struct {
        int rs1, rs2, rd;
        bit we, ld;
    } ins_t;

    localparam int MD_LAT = 4;

    ins_t pipe [3];
    int   md_left;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag      = 0;
    logic [1:0] last_fa;
    logic       last_se;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    function automatic ins_t empty_ins();
        ins_t n;
        n = '{default: 0};
        return n;
    endfunction

    // Nearest older instruction in flight that writes the register wins.
    function automatic logic [1:0] m_fwd(input int rs);
        for (int k = 1; k <= 2; k++) begin
            if (rs != 0 && pipe[k].we && pipe[k].rd == rs) return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic [4:0] m_ctl(input vec_t v);
        bit busy, lu, sf, fe;
        busy = (md_left > 0);
        lu   = pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == int'(v.rs1) || pipe[0].rd == int'(v.rs2));
        sf   = busy || (lu && !v.pc);
        fe   = v.pc || (lu && !busy);
        return {sf, sf, busy, v.pc, fe};
    endfunction

    task automatic m_step(input vec_t v);
        logic [4:0] c;
        ins_t       d;
        if (v.rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
            md_left = 0;
        end else if (md_left > 0) begin
            md_left--;
            pipe[2] = pipe[1];
            pipe[1] = empty_ins();
        end else begin
            c       = m_ctl(v);
            d.rs1   = int'(v.rs1);
            d.rs2   = int'(v.rs2);
            d.rd    = int'(v.rd);
            d.we    = v.we;
            d.ld    = (v.res == RES_LOAD);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = c[0] ? empty_ins() : d;
`ifdef HAZARD_MULDIV_EN
            if (!c[0] && v.md) md_left = MD_LAT - 1;
`endif
        end
    endtask

    // mode 0: no check, 1: check table expectations, 2: check against the model
    task automatic apply(input vec_t v, input int mode);
        logic [4:0] ctl_now;
        rst = v.rst; rs1_d = v.rs1; rs2_d = v.rs2; rd_d = v.rd;
        reg_write_d = v.we; res_src_d = v.res; pc_src_e = v.pc; muldiv_d = v.md;
        #2;
        ctl_now = {stall_f, stall_d, stall_e, flush_d, flush_e};
        if (mode == 1) begin
            chk("tbl_fwd_a", 8'(forward_a_e), 8'(v.fa));
            chk("tbl_fwd_b", 8'(forward_b_e), 8'(v.fb));
            chk("tbl_ctl",   8'(ctl_now),     8'(v.ctl));
        end else if (mode == 2) begin
            chk("mdl_fwd_a", 8'(forward_a_e), 8'(m_fwd(pipe[0].rs1)));
            chk("mdl_fwd_b", 8'(forward_b_e), 8'(m_fwd(pipe[0].rs2)));
            chk("mdl_ctl",   8'(ctl_now),     8'(m_ctl(v)));
        end
        last_fa = forward_a_e;
        last_se = stall_e;
        @(posedge clk);
        m_step(v);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input int a, input int b, input int d, input logic we,
                                input logic [1:0] res, input logic pc,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] ctl);
        vec_t v;
        v.rst = r; v.rs1 = 5'(a); v.rs2 = 5'(b); v.rd = 5'(d); v.we = we; v.res = res;
        v.pc = pc; v.md = 1'b0; v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tv [$];
        vec_t v;
        int   n;

        md_left = 0;
        for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; res_src_d = 0; pc_src_e = 0; muldiv_d = 0;
        @(posedge clk); #1;
        apply(v, 0);
        apply(v, 0);

        //                rst rs1 rs2 rd we res pc  fa fb ctl
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 0, 5'b00000)); // idle after reset
        tv.push_back(mk(0,  1,  2,  5, 1, 0, 0,  0, 0, 5'b00000)); // add x5
        tv.push_back(mk(0,  5,  1,  6, 1, 0, 0,  0, 0, 5'b00000)); // sub x6,x5,x1
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  2, 0, 5'b00000)); // sub in E: M forward
        tv.push_back(mk(0,  3,  4, 10, 1, 0, 0,  0, 0, 5'b00000)); // add x10
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 0, 5'b00000)); // gap
        tv.push_back(mk(0, 10, 10, 11, 1, 0, 0,  0, 0, 5'b00000)); // sub x11,x10,x10
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  1, 1, 5'b00000)); // W forward on A and B
        tv.push_back(mk(0,  1,  0,  7, 1, 1, 0,  0, 0, 5'b00000)); // lw x7
        tv.push_back(mk(0,  7,  7,  8, 1, 0, 0,  0, 0, 5'b11001)); // add x8,x7,x7: load-use
        tv.push_back(mk(0,  7,  7,  8, 1, 0, 0,  0, 0, 5'b00000)); // held add, bubble in E
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  1, 1, 5'b00000)); // load forwarded from W
        tv.push_back(mk(0,  2,  0,  0, 1, 1, 0,  0, 0, 5'b00000)); // lw x0
        tv.push_back(mk(0,  0,  0,  0, 1, 0, 0,  0, 0, 5'b00000)); // add x0: no stall on x0 load
        tv.push_back(mk(0,  0,  0, 12, 1, 0, 0,  0, 0, 5'b00000)); // add x12,x0,x0
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 0, 5'b00000)); // x0 writers in M and W
        tv.push_back(mk(0,  1,  0, 13, 1, 1, 0,  0, 0, 5'b00000)); // lw x13
        tv.push_back(mk(0, 13,  0, 14, 1, 0, 1,  0, 0, 5'b00011)); // load-use + branch: flush wins
        tv.push_back(mk(0, 14, 13, 15, 1, 0, 0,  0, 0, 5'b00000)); // E is bubble
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 1, 5'b00000)); // x14 never entered E
        tv.push_back(mk(0,  1,  0, 16, 1, 1, 0,  0, 0, 5'b00000)); // lw x16
        tv.push_back(mk(1, 16,  0, 17, 1, 0, 0,  0, 0, 5'b11001)); // reset during load-use
        tv.push_back(mk(0, 16,  0, 17, 1, 0, 0,  0, 0, 5'b00000)); // all cleared
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 0, 5'b00000)); // lw x16 wiped by reset
        tv.push_back(mk(0,  1,  0, 20, 1, 0, 0,  0, 0, 5'b00000)); // add x20 (older)
        tv.push_back(mk(0,  2,  0, 20, 1, 0, 0,  0, 0, 5'b00000)); // add x20 (younger)
        tv.push_back(mk(0, 20, 20, 21, 1, 0, 0,  0, 0, 5'b00000)); // sub x21,x20,x20
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  2, 2, 5'b00000)); // M beats W
        tv.push_back(mk(0,  3,  4, 22, 0, 0, 0,  0, 0, 5'b00000)); // non-writing rd=22
        tv.push_back(mk(0, 22,  0, 23, 1, 0, 0,  0, 0, 5'b00000));
        tv.push_back(mk(0,  0,  0,  0, 0, 0, 0,  0, 0, 5'b00000)); // no forward without reg_write

        foreach (tv[i]) begin
            tag = i;
            apply(tv[i], 1);
        end

`ifdef HAZARD_MULDIV_EN
        tag = 1000;
        v = mk(0, 1, 2, 9, 1, 0, 0, 0, 0, 0);
        v.md = 1'b1;
        apply(v, 2);
        v = mk(0, 9, 0, 10, 1, 0, 0, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            apply(v, 2);
            if (!last_se) break;
            n++;
        end
        chk("md_stall_cycles", 8'(n), 8'(MD_LAT - 1));
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(v, 2);
        chk("md_fwd_m", 8'(last_fa), 8'(2'b10));
`endif

        for (int i = 0; i < 2000; i++) begin
            int r [3];
            tag = 2000 + i;
            for (int k = 0; k < 3; k++) begin
                r[k] = $urandom_range(0, 7);
                if ($urandom_range(0, 3) == 0) r[k] += 16;
            end
            v = mk(($urandom_range(0, 63) == 0), r[0], r[1], r[2], 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), 0, 0, 0);
            v.md = ($urandom_range(0, 7) == 0);
            if (md_left > 0) v.pc = 1'b0;
            apply(v, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
